nco_acq_sweep_ctrl: RTL and testbench
=====================================

// Module: nco_acq_sweep_ctrl
// PURPOSE
//  Carrier-acquisition controller for the Costas-loop NCO: generates the NCO phase increment (phi_inc).
//  Steps the frequency across a search band, dwells on each step and watches a lock metric from the
//  I/Q arm detector; confirms lock, then hands fine control to the loop filter.
//  On loss of lock it resumes the sweep. Sits between the loop filter / lock detector and the NCO phi_inc_i input.
// PARAMETERS
//  PHASE_WIDTH  32  width of phase increment / frequency words (matches NCO)
//  METRIC_WIDTH 16  width of unsigned lock metric and thresholds
//  CONFIRM_N    4   consecutive metric samples >= lock_thresh required to declare lock
//  UNLOCK_N     8   consecutive metric samples < unlock_thresh required to declare loss of lock
// PORTS
//  clk           in   1             system clock
//  reset         in   1             asynchronous reset, active-high
//  enable        in   1             run controller; low forces IDLE
//  f_lo          in   PHASE_WIDTH   sweep start frequency word
//  f_step        in   PHASE_WIDTH   frequency increment per sweep step
//  n_steps       in   16            number of sweep steps per pass (0 treated as 1)
//  dwell_len     in   16            metric samples per step (0 treated as 1)
//  lock_thresh   in   METRIC_WIDTH  lock-acquire threshold
//  unlock_thresh in   METRIC_WIDTH  lock-loss threshold
//  lock_metric   in   METRIC_WIDTH  lock metric sample
//  metric_valid  in   1             lock_metric qualifier, one-cycle strobe
//  loop_corr     in   PHASE_WIDTH   signed loop-filter correction (two's complement)
//  corr_valid    in   1             loop_corr qualifier
//  phi_inc_o     out  PHASE_WIDTH   phase increment to NCO phi_inc_i
//  phi_valid     out  1             phi_inc_o is driven by an active state
//  state_o       out  2             0 IDLE, 1 SWEEP, 2 CONFIRM, 3 TRACK
//  locked        out  1             high only in TRACK
//  sweep_wraps   out  8             completed sweep passes since leaving IDLE, saturates at 255
// BEHAVIOUR
//  Reset: state IDLE, phi_inc_o=0, phi_valid=0, locked=0, sweep_wraps=0, all counters 0.
//  All outputs registered. phi_inc_o reflects freq/corr one cycle after the event that changes it.
//  Arithmetic: all frequency sums are modulo 2^PHASE_WIDTH (wrap, no saturation).
//  f_lo, f_step, n_steps, dwell_len are latched on IDLE->SWEEP; live changes are ignored until re-enable.
//  lock_thresh and unlock_thresh are used live.
//  IDLE: phi_inc_o=f_lo, phi_valid=0. enable=1 -> latch config, freq=f_lo, step=0, dwell=0, wraps=0 -> SWEEP.
//  SWEEP: phi_inc_o=freq. Each metric_valid:
//   - metric >= lock_thresh -> CONFIRM with hits=1. Lock wins over step advance on the same sample.
//   - else dwell++. At dwell==dwell_len-1: dwell=0, step++, freq+=f_step.
//     If step==n_steps-1: freq=f_lo, step=0, wraps++ (sat).
//  CONFIRM: freq held. Each metric_valid: metric >= lock_thresh -> hits++; hits reaching CONFIRM_N -> TRACK.
//   Metric < lock_thresh -> SWEEP, same step, dwell=0.
//   CONFIRM_N=1 -> the SWEEP hit goes directly to TRACK.
//  TRACK: base=freq frozen; locked=1. corr_valid -> phi_inc_o=base+loop_corr (sign-extended).
//   Metric < unlock_thresh -> miss++; metric >= unlock_thresh -> miss=0.
//   miss reaching UNLOCK_N -> SWEEP at same step, dwell=0, correction cleared (phi_inc_o=base next cycle).
//  corr_valid is ignored outside TRACK. metric_valid is ignored in IDLE.
//  enable=0 in any state -> IDLE next cycle; phi_valid=0, locked=0, phi_inc_o=f_lo. wraps retained until re-enable.
//  Reset mid-operation: immediate return to reset values regardless of state.
//  phi_valid=1 in SWEEP, CONFIRM and TRACK.
// TESTING
//  f_lo=1000, f_step=100, n_steps=3, dwell=2, metric always 0 ->
//   phi_inc_o 1000,1000,1100,1100,1200,1200,1000; sweep_wraps=1 after 6 samples.
//  Sweep as above; metric=lock_thresh on the last dwell sample of step 1 ->
//   CONFIRM, phi_inc_o stays 1100 (no advance).
//  CONFIRM with 3 hits then 1 miss (CONFIRM_N=4) -> back to SWEEP at 1100, dwell restarts, locked stays 0.
//  4 hits -> TRACK, locked=1; loop_corr=-5 with corr_valid -> phi_inc_o=1095 next cycle;
//   7 misses then 1 good sample -> still TRACK.
//  TRACK with 8 consecutive metrics < unlock_thresh -> SWEEP, phi_inc_o=1100, locked=0.
//  f_lo=32'hFFFF_FFF0, f_step=32'h20 -> second step phi_inc_o=32'h10 (wrap).
//  enable drop mid-CONFIRM -> IDLE next cycle.
//  reset pulse mid-TRACK -> all outputs 0 asynchronously.

Source files
------------

// File: rtl/nco_acq_sweep_ctrl.sv
// Carrier-acquisition controller for the Costas-loop NCO. It sweeps phi_inc across a band,
// confirms lock from the arm-detector metric, then passes fine control to the loop filter.
//
//  state   | meaning
//  IDLE    | disabled, phi_inc follows f_lo, outputs not valid
//  SWEEP   | stepping freq, dwell_len metric samples per step
//  CONFIRM | freq held, counting consecutive lock hits
//  TRACK   | freq frozen as base, loop correction applied, watching for loss of lock
module nco_acq_sweep_ctrl #(
  parameter int PHASE_WIDTH  = 32,
  parameter int METRIC_WIDTH = 16,
  parameter int CONFIRM_N    = 4,
  parameter int UNLOCK_N     = 8
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    enable,
  input  logic [PHASE_WIDTH-1:0]  f_lo,
  input  logic [PHASE_WIDTH-1:0]  f_step,
  input  logic [15:0]             n_steps,
  input  logic [15:0]             dwell_len,
  input  logic [METRIC_WIDTH-1:0] lock_thresh,
  input  logic [METRIC_WIDTH-1:0] unlock_thresh,
  input  logic [METRIC_WIDTH-1:0] lock_metric,
  input  logic                    metric_valid,
  input  logic [PHASE_WIDTH-1:0]  loop_corr,
  input  logic                    corr_valid,
  output logic [PHASE_WIDTH-1:0]  phi_inc_o,
  output logic                    phi_valid,
  output logic [1:0]              state_o,
  output logic                    locked,
  output logic [7:0]              sweep_wraps
);

  localparam int HW = $clog2(CONFIRM_N + 1);
  localparam int UW = $clog2(UNLOCK_N + 1);

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_SWEEP   = 2'd1,
    S_CONFIRM = 2'd2,
    S_TRACK   = 2'd3
  } state_t;

  state_t                  state_q, state_d;
  logic [PHASE_WIDTH-1:0]  freq_q, freq_d;
  logic [PHASE_WIDTH-1:0]  f_lo_q, f_lo_d;
  logic [PHASE_WIDTH-1:0]  f_step_q, f_step_d;
  logic [15:0]             n_steps_q, n_steps_d;
  logic [15:0]             dwell_len_q, dwell_len_d;
  logic [15:0]             step_q, step_d;
  logic [15:0]             dwell_q, dwell_d;
  logic [HW-1:0]           hits_q, hits_d;
  logic [UW-1:0]           miss_q, miss_d;
  logic [7:0]              wraps_q, wraps_d;
  logic [PHASE_WIDTH-1:0]  phi_q, phi_d;
  logic                    phi_valid_q, phi_valid_d;
  logic                    locked_q, locked_d;

  logic lock_hit;
  logic track_miss;

  assign lock_hit   = metric_valid && (lock_metric >= lock_thresh);
  assign track_miss = metric_valid && (lock_metric < unlock_thresh);

  always_comb begin
    state_d     = state_q;
    freq_d      = freq_q;
    f_lo_d      = f_lo_q;
    f_step_d    = f_step_q;
    n_steps_d   = n_steps_q;
    dwell_len_d = dwell_len_q;
    step_d      = step_q;
    dwell_d     = dwell_q;
    hits_d      = hits_q;
    miss_d      = miss_q;
    wraps_d     = wraps_q;
    phi_d       = phi_q;

    case (state_q)
      S_IDLE: begin
        phi_d = f_lo;
        if (enable) begin
          f_lo_d      = f_lo;
          f_step_d    = f_step;
          n_steps_d   = (n_steps == 16'd0) ? 16'd1 : n_steps;
          dwell_len_d = (dwell_len == 16'd0) ? 16'd1 : dwell_len;
          freq_d      = f_lo;
          step_d      = '0;
          dwell_d     = '0;
          hits_d      = '0;
          miss_d      = '0;
          wraps_d     = '0;
          state_d     = S_SWEEP;
        end
      end

      S_SWEEP: begin
        if (lock_hit) begin
          // a hit on the last dwell sample must not advance the step
          hits_d  = HW'(1);
          miss_d  = '0;
          state_d = (CONFIRM_N <= 1) ? S_TRACK : S_CONFIRM;
        end else if (metric_valid) begin
          if (dwell_q == dwell_len_q - 16'd1) begin
            dwell_d = '0;
            if (step_q == n_steps_q - 16'd1) begin
              step_d  = '0;
              freq_d  = f_lo_q;
              wraps_d = (wraps_q == 8'hFF) ? wraps_q : wraps_q + 8'd1;
            end else begin
              step_d = step_q + 16'd1;
              freq_d = freq_q + f_step_q;
            end
          end else begin
            dwell_d = dwell_q + 16'd1;
          end
        end
        phi_d = freq_d;
      end

      S_CONFIRM: begin
        if (lock_hit) begin
          hits_d = hits_q + HW'(1);
          if (hits_q >= HW'(CONFIRM_N - 1)) begin
            miss_d  = '0;
            state_d = S_TRACK;
          end
        end else if (metric_valid) begin
          dwell_d = '0;
          state_d = S_SWEEP;
        end
        phi_d = freq_q;
      end

      S_TRACK: begin
        if (track_miss) begin
          if (miss_q >= UW'(UNLOCK_N - 1)) begin
            miss_d  = '0;
            dwell_d = '0;
            state_d = S_SWEEP;
          end else begin
            miss_d = miss_q + UW'(1);
          end
        end else if (metric_valid) begin
          miss_d = '0;
        end
        // loss of lock drops the correction even if one arrives the same cycle
        if (state_d == S_SWEEP) begin
          phi_d = freq_q;
        end else if (corr_valid) begin
          phi_d = freq_q + loop_corr;
        end
      end

      default: state_d = S_IDLE;
    endcase

    if (!enable) begin
      state_d = S_IDLE;
      phi_d   = f_lo;
    end

    phi_valid_d = (state_d != S_IDLE);
    locked_d    = (state_d == S_TRACK);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= S_IDLE;
      freq_q      <= '0;
      f_lo_q      <= '0;
      f_step_q    <= '0;
      n_steps_q   <= '0;
      dwell_len_q <= '0;
      step_q      <= '0;
      dwell_q     <= '0;
      hits_q      <= '0;
      miss_q      <= '0;
      wraps_q     <= '0;
      phi_q       <= '0;
      phi_valid_q <= 1'b0;
      locked_q    <= 1'b0;
    end else begin
      state_q     <= state_d;
      freq_q      <= freq_d;
      f_lo_q      <= f_lo_d;
      f_step_q    <= f_step_d;
      n_steps_q   <= n_steps_d;
      dwell_len_q <= dwell_len_d;
      step_q      <= step_d;
      dwell_q     <= dwell_d;
      hits_q      <= hits_d;
      miss_q      <= miss_d;
      wraps_q     <= wraps_d;
      phi_q       <= phi_d;
      phi_valid_q <= phi_valid_d;
      locked_q    <= locked_d;
    end
  end

  assign phi_inc_o   = phi_q;
  assign phi_valid   = phi_valid_q;
  assign state_o     = state_q;
  assign locked      = locked_q;
  assign sweep_wraps = wraps_q;

endmodule

// File: tb/tb_nco_acq_sweep_ctrl.sv
// Directed bench for nco_acq_sweep_ctrl: sweep, confirm, track, unlock, wrap and reset cases
// with hand-computed expected values.
module tb_nco_acq_sweep_ctrl;

  logic        clk = 1'b0;
  logic        reset;
  logic        enable;
  logic [31:0] f_lo, f_step, loop_corr;
  logic [15:0] n_steps, dwell_len;
  logic [15:0] lock_thresh, unlock_thresh, lock_metric;
  logic        metric_valid, corr_valid;
  logic [31:0] phi_inc_o;
  logic        phi_valid;
  logic [1:0]  state_o;
  logic        locked;
  logic [7:0]  sweep_wraps;

  int errors = 0;
  int checks = 0;

  nco_acq_sweep_ctrl dut (
    .clk           (clk),
    .reset         (reset),
    .enable        (enable),
    .f_lo          (f_lo),
    .f_step        (f_step),
    .n_steps       (n_steps),
    .dwell_len     (dwell_len),
    .lock_thresh   (lock_thresh),
    .unlock_thresh (unlock_thresh),
    .lock_metric   (lock_metric),
    .metric_valid  (metric_valid),
    .loop_corr     (loop_corr),
    .corr_valid    (corr_valid),
    .phi_inc_o     (phi_inc_o),
    .phi_valid     (phi_valid),
    .state_o       (state_o),
    .locked        (locked),
    .sweep_wraps   (sweep_wraps)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic samp(input logic [15:0] m);
    lock_metric  = m;
    metric_valid = 1'b1;
    tick();
    metric_valid = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] exp_phi [6];
    exp_phi[0] = 32'd1000; exp_phi[1] = 32'd1100; exp_phi[2] = 32'd1100;
    exp_phi[3] = 32'd1200; exp_phi[4] = 32'd1200; exp_phi[5] = 32'd1000;

    reset = 1'b1; enable = 1'b0;
    f_lo = 32'd1000; f_step = 32'd100; n_steps = 16'd3; dwell_len = 16'd2;
    lock_thresh = 16'd500; unlock_thresh = 16'd200;
    lock_metric = '0; metric_valid = 1'b0; loop_corr = '0; corr_valid = 1'b0;
    #22;
    chk("rst_phi", phi_inc_o, 32'd0);
    chk("rst_valid", {31'd0, phi_valid}, 32'd0);
    chk("rst_state", {30'd0, state_o}, 32'd0);
    chk("rst_locked", {31'd0, locked}, 32'd0);
    chk("rst_wraps", {24'd0, sweep_wraps}, 32'd0);
    reset = 1'b0;
    tick();
    chk("idle_phi", phi_inc_o, 32'd1000);
    chk("idle_valid", {31'd0, phi_valid}, 32'd0);

    enable = 1'b1;
    tick();
    chk("sweep_state", {30'd0, state_o}, 32'd1);
    chk("sweep_valid", {31'd0, phi_valid}, 32'd1);
    chk("sweep_phi0", phi_inc_o, 32'd1000);

    // one full pass with metric 0
    for (int i = 0; i < 6; i++) begin
      samp(16'd0);
      chk($sformatf("sweep_phi_s%0d", i + 1), phi_inc_o, exp_phi[i]);
      chk($sformatf("sweep_wraps_s%0d", i + 1), {24'd0, sweep_wraps}, (i == 5) ? 32'd1 : 32'd0);
    end

    // lock hit on the last dwell sample of step 1 must not advance
    samp(16'd0);
    samp(16'd0);
    chk("step1_phi", phi_inc_o, 32'd1100);
    samp(16'd0);
    samp(16'd500);
    chk("confirm_state", {30'd0, state_o}, 32'd2);
    chk("confirm_phi", phi_inc_o, 32'd1100);

    // 3 hits then a miss -> back to SWEEP with dwell restarted
    samp(16'd500);
    samp(16'd600);
    chk("confirm3_state", {30'd0, state_o}, 32'd2);
    samp(16'd10);
    chk("cmiss_state", {30'd0, state_o}, 32'd1);
    chk("cmiss_phi", phi_inc_o, 32'd1100);
    chk("cmiss_locked", {31'd0, locked}, 32'd0);
    samp(16'd0);
    chk("dwell_restart_phi", phi_inc_o, 32'd1100);

    // 4 hits -> TRACK
    samp(16'd500);
    samp(16'd500);
    samp(16'd500);
    chk("hit3_state", {30'd0, state_o}, 32'd2);
    chk("hit3_locked", {31'd0, locked}, 32'd0);
    samp(16'd500);
    chk("track_state", {30'd0, state_o}, 32'd3);
    chk("track_locked", {31'd0, locked}, 32'd1);
    chk("track_phi", phi_inc_o, 32'd1100);

    loop_corr = 32'hFFFF_FFFB;
    corr_valid = 1'b1;
    tick();
    corr_valid = 1'b0;
    chk("corr_phi", phi_inc_o, 32'd1095);

    // 7 misses then a good sample clears the miss count
    for (int i = 0; i < 7; i++) samp(16'd100);
    samp(16'd300);
    chk("miss7_state", {30'd0, state_o}, 32'd3);
    for (int i = 0; i < 7; i++) samp(16'd100);
    chk("miss7b_state", {30'd0, state_o}, 32'd3);
    chk("miss7b_phi", phi_inc_o, 32'd1095);
    samp(16'd100);
    chk("unlock_state", {30'd0, state_o}, 32'd1);
    chk("unlock_phi", phi_inc_o, 32'd1100);
    chk("unlock_locked", {31'd0, locked}, 32'd0);

    corr_valid = 1'b1;
    tick();
    corr_valid = 1'b0;
    chk("corr_ignored_phi", phi_inc_o, 32'd1100);

    // enable drop mid-CONFIRM
    samp(16'd500);
    chk("confirm2_state", {30'd0, state_o}, 32'd2);
    enable = 1'b0;
    tick();
    chk("dis_state", {30'd0, state_o}, 32'd0);
    chk("dis_phi", phi_inc_o, 32'd1000);
    chk("dis_valid", {31'd0, phi_valid}, 32'd0);
    chk("dis_wraps", {24'd0, sweep_wraps}, 32'd1);

    // wraparound arithmetic, dwell_len=0 treated as 1, live config ignored
    f_lo = 32'hFFFF_FFF0; f_step = 32'h20; dwell_len = 16'd0;
    tick();
    chk("idle2_phi", phi_inc_o, 32'hFFFF_FFF0);
    enable = 1'b1;
    tick();
    chk("sweep2_wraps", {24'd0, sweep_wraps}, 32'd0);
    f_step = 32'd5;
    samp(16'd0);
    chk("wrap_phi1", phi_inc_o, 32'h10);
    samp(16'd0);
    chk("wrap_phi2", phi_inc_o, 32'h30);
    samp(16'd0);
    chk("wrap_phi3", phi_inc_o, 32'hFFFF_FFF0);
    chk("wrap_wraps", {24'd0, sweep_wraps}, 32'd1);

    // reach TRACK and reset asynchronously
    samp(16'd500);
    samp(16'd500);
    samp(16'd500);
    samp(16'd500);
    chk("track2_locked", {31'd0, locked}, 32'd1);
    reset = 1'b1;
    #2;
    chk("arst_phi", phi_inc_o, 32'd0);
    chk("arst_valid", {31'd0, phi_valid}, 32'd0);
    chk("arst_state", {30'd0, state_o}, 32'd0);
    chk("arst_locked", {31'd0, locked}, 32'd0);
    chk("arst_wraps", {24'd0, sweep_wraps}, 32'd0);
    reset = 1'b0;
    tick();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
